fft_source_collector: RTL

Receives the Avalon-ST output stream of the 256-point FFT core: real/imag pairs framed by start/end-of-packet. Checks each packet's framing and computes an alpha-max-beta-min magnitude per bin. Good frames go into a ping-pong bin buffer, and a random-access read port serves the completed frame to the display/analysis logic. Incomplete or errored frames are discarded, and the published buffer keeps the last good frame.

---
 rtl/fft_source_collector_pkg.sv | 32 +++
 rtl/fft_mag_approx.sv | 31 +++
 rtl/fft_source_collector.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/fft_source_collector_pkg.sv
// Shared definitions for the FFT source collector.
//   FFT_LENGTH / ADDR_W : bins per packet and bin address width
//   SAMPLE_W / MAG_W    : FFT sample width and stored magnitude width
//   RAW_W               : width of the unshifted alpha-max-beta-min sum
//   state_e             : packet framing FSM states
//   abs_sat()           : magnitude of a signed sample, most-negative clamped
package fft_pkg;

  localparam int unsigned FFT_LENGTH = 256;
  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned SAMPLE_W   = 18;
  localparam int unsigned MAG_W      = 16;
  localparam int unsigned RAW_W      = 19;

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StDrop
  } state_e;

  // |x| in SAMPLE_W-1 bits; -2^(SAMPLE_W-1) has no positive twin and clamps to all ones.
  function automatic logic [SAMPLE_W-2:0] abs_sat(input logic [SAMPLE_W-1:0] x);
    if (!x[SAMPLE_W-1]) begin
      return x[SAMPLE_W-2:0];
    end
    if (x[SAMPLE_W-2:0] == '0) begin
      return '1;
    end
    return (~x[SAMPLE_W-2:0]) + {{(SAMPLE_W-2){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/fft_mag_approx.sv
// Combinational alpha-max-beta-min magnitude estimate.
//   re, im : signed FFT sample pair
//   mag    : (max(|re|,|im|) + min(|re|,|im|)/2) >> MAG_SHIFT, saturated to MAG_W bits
module fft_mag_approx
  import fft_pkg::*;
#(
  parameter int unsigned MAG_SHIFT = 2
) (
  input  logic [SAMPLE_W-1:0] re,
  input  logic [SAMPLE_W-1:0] im,
  output logic [MAG_W-1:0]    mag
);

  logic [SAMPLE_W-2:0] a;
  logic [SAMPLE_W-2:0] b;
  logic [SAMPLE_W-2:0] hi;
  logic [SAMPLE_W-2:0] lo;
  logic [RAW_W-1:0]    raw;
  logic [RAW_W-1:0]    scaled;

  always_comb begin
    a      = abs_sat(re);
    b      = abs_sat(im);
    hi     = (a > b) ? a : b;
    lo     = (a > b) ? b : a;
    raw    = RAW_W'(hi) + RAW_W'(lo >> 1);
    scaled = raw >> MAG_SHIFT;
    mag    = (|scaled[RAW_W-1:MAG_W]) ? '1 : scaled[MAG_W-1:0];
  end

endmodule

// File: rtl/fft_source_collector.sv
// Collects 256-bin FFT packets from an Avalon-ST source, checks framing and
// stores per-bin magnitudes into a ping-pong buffer; the last good frame is
// served through a registered random-access read port.
//   clk, rst_n           : clock, synchronous active-low reset
//   source_*             : Avalon-ST sink (real/imag, valid, sop, eop, error)
//   source_ready         : high whenever out of reset (no back-pressure)
//   rd_addr / rd_data    : bin read port, one cycle latency, 0 until first publish
//   frame_done           : one-cycle pulse when a good frame is published
//   frame_count          : number of published frames (wraps)
//   err_sticky           : a frame has been discarded since reset
module fft_source_collector
  import fft_pkg::*;
#(
  parameter int unsigned MAG_SHIFT = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] source_real,
  input  logic [SAMPLE_W-1:0] source_imag,
  input  logic                source_valid,
  input  logic                source_startofpacket,
  input  logic                source_endofpacket,
  input  logic [1:0]          source_error,
  output logic                source_ready,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [MAG_W-1:0]    rd_data,
  output logic                frame_done,
  output logic [15:0]         frame_count,
  output logic                err_sticky
);

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(FFT_LENGTH - 1);
  localparam logic [ADDR_W-1:0] OneIdx  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state_q;
  logic [ADDR_W-1:0] wr_idx_q;
  logic              bad_q;
  logic              ready_q;
  logic              err_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [MAG_W-1:0]  mag_q;
  logic              pub_q;
  logic              bank_sel_q;
  logic              have_frame_q;
  logic              frame_done_q;
  logic [15:0]       frame_count_q;
  logic [MAG_W-1:0]  rd_data_q;
  logic [MAG_W-1:0]  mag_c;

  logic [MAG_W-1:0]  bank0 [FFT_LENGTH];
  logic [MAG_W-1:0]  bank1 [FFT_LENGTH];

  logic beat;
  logic beat_err;
  logic last;

  assign beat     = source_valid & ready_q;
  assign beat_err = |source_error;
  assign last     = (wr_idx_q == LastIdx);

  fft_mag_approx #(
    .MAG_SHIFT(MAG_SHIFT)
  ) u_mag (
    .re (source_real),
    .im (source_imag),
    .mag(mag_c)
  );

  // Framing FSM plus the one-stage magnitude/write pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      wr_idx_q  <= '0;
      bad_q     <= 1'b0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      mag_q     <= '0;
      pub_q     <= 1'b0;
    end else begin
      ready_q   <= 1'b1;
      mag_q     <= mag_c;
      wr_en_q   <= 1'b0;
      wr_addr_q <= wr_idx_q;
      pub_q     <= 1'b0;
      if (beat) begin
        if (source_startofpacket) begin
          // sop always opens a fresh frame; an interrupted frame is lost
          if (state_q == StRecv) err_q <= 1'b1;
          state_q   <= StRecv;
          wr_idx_q  <= OneIdx;
          wr_addr_q <= '0;
          wr_en_q   <= 1'b1;
          bad_q     <= beat_err;
        end else if (state_q == StRecv) begin
          if (source_endofpacket) begin
            state_q  <= StIdle;
            wr_idx_q <= '0;
            if (last && !bad_q && !beat_err) begin
              wr_en_q <= 1'b1;
              pub_q   <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end else if (last) begin
            state_q  <= StDrop;
            wr_idx_q <= '0;
            err_q    <= 1'b1;
          end else begin
            wr_en_q  <= 1'b1;
            wr_idx_q <= wr_idx_q + OneIdx;
            bad_q    <= bad_q | beat_err;
          end
        end else if (source_endofpacket) begin
          state_q <= StIdle;
        end
      end
    end
  end

  // Publish and read port. The final bin write shares the edge with the bank
  // swap and still lands in the old write bank.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_sel_q    <= 1'b0;
      have_frame_q  <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      rd_data_q     <= '0;
    end else begin
      frame_done_q <= pub_q;
      if (pub_q) begin
        bank_sel_q    <= ~bank_sel_q;
        have_frame_q  <= 1'b1;
        frame_count_q <= frame_count_q + 16'd1;
      end
      if (!have_frame_q) begin
        rd_data_q <= '0;
      end else if (bank_sel_q) begin
        rd_data_q <= bank1[rd_addr];
      end else begin
        rd_data_q <= bank0[rd_addr];
      end
    end
  end

  // Writes target the bank not being read.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en_q) begin
      if (bank_sel_q) begin
        bank0[wr_addr_q] <= mag_q;
      end else begin
        bank1[wr_addr_q] <= mag_q;
      end
    end
  end

  assign source_ready = ready_q;
  assign rd_data      = rd_data_q;
  assign frame_done   = frame_done_q;
  assign frame_count  = frame_count_q;
  assign err_sticky   = err_q;

endmodule
